// File: rtl/sort_mem_arbiter.sv
// sort_mem_arbiter
// Two-requester arbiter in front of the sorter's shared synchronous RAM.
// Requester A is the user load/readback port, requester B the sort engine.
// One access per cycle, round-robin priority in IDLE, optional multi-cycle
// lock per requester bounded by MAX_LOCK so neither side can starve.
//
// Lock accounting: lock_cnt_r holds the number of locked cycles already
// completed, including the IDLE grant cycle that took the lock. A lock is
// force-released at the end of the cycle that makes the total reach
// MAX_LOCK, so MAX_LOCK = N gives the owner exactly N consecutive cycles
// and MAX_LOCK = 1 never leaves IDLE at all.
module sort_mem_arbiter #(
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          lock_a,
  input  logic          lock_b,
  input  logic          wr_a,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_wraddr,
  output logic [AW-1:0] mem_rdaddr,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_A    = 2'd1,
    TAG_B    = 2'd2
  } tag_t;

  // prio_r encoding: 0 = A has priority, 1 = B has priority.
  localparam logic       PRIO_A      = 1'b0;
  localparam logic       PRIO_B      = 1'b1;
  localparam logic [7:0] MAX_LOCK_C  = 8'(MAX_LOCK);
  localparam bit         LIMITED_C   = (MAX_LOCK != 0);
  localparam bit         ONE_CYCLE_C = (MAX_LOCK == 1);

  state_t     state_r;
  logic       prio_r;
  logic [7:0] lock_cnt_r;
  tag_t       rtag_r;

  logic          any_gnt_s;
  logic          sel_wr_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          win_lock_s;
  logic [7:0]    cnt_inc_s;
  logic          limit_hit_s;

  // Grant decision: owner-only while locked, priority tie-break in IDLE.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else begin
      case (state_r)
        LOCK_A: begin
          gnt_a = req_a;
          gnt_b = 1'b0;
        end
        LOCK_B: begin
          gnt_a = 1'b0;
          gnt_b = req_b;
        end
        default: begin
          if (req_a && req_b) begin
            gnt_a = (prio_r == PRIO_A);
            gnt_b = (prio_r == PRIO_B);
          end else begin
            gnt_a = req_a;
            gnt_b = req_b;
          end
        end
      endcase
    end
  end

  // Select the granted requester's access fields and lock request.
  always_comb begin
    any_gnt_s = gnt_a | gnt_b;
    if (gnt_b) begin
      sel_wr_s    = wr_b;
      sel_addr_s  = addr_b;
      sel_wdata_s = wdata_b;
      win_lock_s  = lock_b;
    end else begin
      sel_wr_s    = wr_a;
      sel_addr_s  = addr_a;
      sel_wdata_s = wdata_a;
      win_lock_s  = lock_a;
    end
  end

  // Drive the RAM port; unused address/data lines are held at zero.
  always_comb begin
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wraddr = '0;
    mem_rdaddr = '0;
    mem_datain = '0;
    if (any_gnt_s) begin
      if (sel_wr_s) begin
        mem_wr     = 1'b1;
        mem_wraddr = sel_addr_s;
        mem_datain = sel_wdata_s;
      end else begin
        mem_rd     = 1'b1;
        mem_rdaddr = sel_addr_s;
      end
    end else begin
      mem_wr = 1'b0;
      mem_rd = 1'b0;
    end
  end

  // Saturating lock counter increment and the forced-release test.
  always_comb begin
    if (lock_cnt_r == 8'hFF) begin
      cnt_inc_s = 8'hFF;
    end else begin
      cnt_inc_s = lock_cnt_r + 8'd1;
    end
    limit_hit_s = LIMITED_C && (cnt_inc_s == MAX_LOCK_C);
  end

  // Arbiter FSM: ownership, round-robin priority, lock count and read tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      prio_r     <= PRIO_A;
      lock_cnt_r <= 8'd0;
      rtag_r     <= TAG_NONE;
    end else begin
      if (any_gnt_s && !sel_wr_s) begin
        rtag_r <= gnt_b ? TAG_B : TAG_A;
      end else begin
        rtag_r <= TAG_NONE;
      end

      case (state_r)
        LOCK_A: begin
          if (!lock_a) begin
            state_r    <= IDLE;
            lock_cnt_r <= 8'd0;
          end else if (limit_hit_s) begin
            state_r    <= IDLE;
            prio_r     <= PRIO_B;
            lock_cnt_r <= 8'd0;
          end else begin
            lock_cnt_r <= cnt_inc_s;
          end
        end
        LOCK_B: begin
          if (!lock_b) begin
            state_r    <= IDLE;
            lock_cnt_r <= 8'd0;
          end else if (limit_hit_s) begin
            state_r    <= IDLE;
            prio_r     <= PRIO_A;
            lock_cnt_r <= 8'd0;
          end else begin
            lock_cnt_r <= cnt_inc_s;
          end
        end
        IDLE: begin
          if (any_gnt_s) begin
            // The loser of this grant gets priority next time.
            prio_r <= gnt_a ? PRIO_B : PRIO_A;
            if (win_lock_s && !ONE_CYCLE_C) begin
              state_r    <= gnt_a ? LOCK_A : LOCK_B;
              lock_cnt_r <= 8'd1;
            end else begin
              state_r    <= IDLE;
              lock_cnt_r <= 8'd0;
            end
          end else begin
            state_r    <= IDLE;
            lock_cnt_r <= 8'd0;
          end
        end
        default: begin
          state_r    <= IDLE;
          lock_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Read return: the tag registered at issue time names the receiver.
  always_comb begin
    rdata = mem_dataout;
    if (rst) begin
      rvalid_a = 1'b0;
      rvalid_b = 1'b0;
    end else begin
      rvalid_a = (rtag_r == TAG_A);
      rvalid_b = (rtag_r == TAG_B);
    end
  end

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// tb_sort_mem_arbiter
// Three arbiters (MAX_LOCK = 16, 4, 1) share one directed stimulus stream.
// Each has its own RAM model; a behavioural reference checks every output
// of every instance on every falling edge, and directed literal checks pin
// the scenarios of interest.
module tb_sort_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, req_b, lock_a, lock_b, wr_a, wr_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;

  logic       gnt_a_o [3];
  logic       gnt_b_o [3];
  logic       rvalid_a_o [3];
  logic       rvalid_b_o [3];
  logic       mem_wr_o [3];
  logic       mem_rd_o [3];
  logic [2:0] mem_wraddr_o [3];
  logic [2:0] mem_rdaddr_o [3];
  logic [7:0] mem_datain_o [3];
  logic [7:0] rdata_o [3];
  logic [7:0] mem_dataout_i [3];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [7:0] ram [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [7:0] dout = 8'h00;

    sort_mem_arbiter #(
      .AW(3), .DW(8), .MAX_LOCK(g == 0 ? 16 : (g == 1 ? 4 : 1))
    ) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b), .lock_a(lock_a), .lock_b(lock_b),
      .wr_a(wr_a), .wr_b(wr_b), .addr_a(addr_a), .addr_b(addr_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .gnt_a(gnt_a_o[g]), .gnt_b(gnt_b_o[g]),
      .rvalid_a(rvalid_a_o[g]), .rvalid_b(rvalid_b_o[g]),
      .rdata(rdata_o[g]),
      .mem_wr(mem_wr_o[g]), .mem_rd(mem_rd_o[g]),
      .mem_wraddr(mem_wraddr_o[g]), .mem_rdaddr(mem_rdaddr_o[g]),
      .mem_datain(mem_datain_o[g]), .mem_dataout(mem_dataout_i[g])
    );

    always @(posedge clk) begin
      if (mem_wr_o[g]) ram[mem_wraddr_o[g]] <= mem_datain_o[g];
      if (mem_rd_o[g]) dout <= ram[mem_rdaddr_o[g]];
    end

    assign mem_dataout_i[g] = dout;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // owner: 0 nobody, 1 A, 2 B. held: locked cycles so far including grant.
  int         m_owner [3];
  int         m_held [3];
  int         m_prio [3];   // 0 A first, 1 B first
  int         m_pend [3];   // receiver of the read issued last cycle
  logic [7:0] m_pdata [3];
  logic [7:0] m_mem [3][8];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = 0; m_held[i] = 0; m_prio[i] = 0; m_pend[i] = 0;
      m_pdata[i] = 8'h00;
      for (int k = 0; k < 8; k++) m_mem[i][k] = 8'h10 + 8'(k);
    end
  end

  task automatic model_cycle(input int i);
    int         win, lim, prev_owner;
    logic       w_wr, w_lock, own_lock, e_wr, e_rd, e_rva, e_rvb;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    lim = (i == 0) ? 16 : ((i == 1) ? 4 : 1);
    win = 0;
    if (!rst) begin
      if (m_owner[i] == 1) win = req_a ? 1 : 0;
      else if (m_owner[i] == 2) win = req_b ? 2 : 0;
      else if (req_a && req_b) win = (m_prio[i] == 0) ? 1 : 2;
      else if (req_a) win = 1;
      else if (req_b) win = 2;
    end
    w_wr   = (win == 2) ? wr_b : wr_a;
    w_lock = (win == 2) ? lock_b : lock_a;
    w_addr = (win == 2) ? addr_b : addr_a;
    w_data = (win == 2) ? wdata_b : wdata_a;
    e_wr = (win != 0) && w_wr;
    e_rd = (win != 0) && !w_wr;
    e_rva = !rst && (m_pend[i] == 1);
    e_rvb = !rst && (m_pend[i] == 2);

    chk($sformatf("u%0d gnt_a", i), 8'(gnt_a_o[i]), 8'(win == 1));
    chk($sformatf("u%0d gnt_b", i), 8'(gnt_b_o[i]), 8'(win == 2));
    chk($sformatf("u%0d mem_wr", i), 8'(mem_wr_o[i]), 8'(e_wr));
    chk($sformatf("u%0d mem_rd", i), 8'(mem_rd_o[i]), 8'(e_rd));
    chk($sformatf("u%0d mem_wraddr", i), 8'(mem_wraddr_o[i]), e_wr ? 8'(w_addr) : 8'h00);
    chk($sformatf("u%0d mem_rdaddr", i), 8'(mem_rdaddr_o[i]), e_rd ? 8'(w_addr) : 8'h00);
    chk($sformatf("u%0d mem_datain", i), mem_datain_o[i], e_wr ? w_data : 8'h00);
    chk($sformatf("u%0d rvalid_a", i), 8'(rvalid_a_o[i]), 8'(e_rva));
    chk($sformatf("u%0d rvalid_b", i), 8'(rvalid_b_o[i]), 8'(e_rvb));
    if (e_rva || e_rvb) chk($sformatf("u%0d rdata", i), rdata_o[i], m_pdata[i]);

    if (rst) begin
      m_owner[i] = 0; m_held[i] = 0; m_prio[i] = 0; m_pend[i] = 0;
    end else begin
      if (e_wr) m_mem[i][w_addr] = w_data;
      if (e_rd) begin
        m_pend[i]  = win;
        m_pdata[i] = m_mem[i][w_addr];
      end else begin
        m_pend[i] = 0;
      end
      prev_owner = m_owner[i];
      if (prev_owner == 0) begin
        if (win != 0) begin
          m_prio[i] = (win == 1) ? 1 : 0;
          if (w_lock && lim != 1) begin
            m_owner[i] = win;
            m_held[i]  = 1;
          end
        end
      end else begin
        m_held[i] = m_held[i] + 1;
        own_lock = (prev_owner == 1) ? lock_a : lock_b;
        if (!own_lock) begin
          m_owner[i] = 0;
        end else if (lim != 0 && m_held[i] == lim) begin
          m_owner[i] = 0;
          m_prio[i]  = (prev_owner == 1) ? 1 : 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) model_cycle(i);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_a(input logic r, input logic l, input logic w,
                       input logic [2:0] ad, input logic [7:0] d);
    req_a = r; lock_a = l; wr_a = w; addr_a = ad; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic l, input logic w,
                       input logic [2:0] ad, input logic [7:0] d);
    req_b = r; lock_b = l; wr_b = w; addr_b = ad; wdata_b = d;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with both requesting: nothing may be granted or issued.
    rst = 1'b1;
    set_a(1'b1, 1'b0, 1'b0, 3'd2, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 3'd5, 8'h00);
    settle();
    chk("reset gnt_a", 8'(gnt_a_o[0]), 8'h00);
    chk("reset gnt_b", 8'(gnt_b_o[0]), 8'h00);
    chk("reset rvalid_a", 8'(rvalid_a_o[0]), 8'h00);
    chk("reset rvalid_b", 8'(rvalid_b_o[0]), 8'h00);
    chk("reset mem_wr", 8'(mem_wr_o[0]), 8'h00);
    chk("reset mem_rd", 8'(mem_rd_o[0]), 8'h00);
    chk("reset mem_rdaddr", 8'(mem_rdaddr_o[0]), 8'h00);
    chk("reset mem_datain", mem_datain_o[0], 8'h00);
    next_cyc();
    rst = 1'b0;

    // Both read (A addr 2, B addr 5) for 4 cycles: A,B,A,B.
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("rr gnt_a", 8'(gnt_a_o[0]), 8'((c % 2) == 0));
      chk("rr gnt_b", 8'(gnt_b_o[0]), 8'((c % 2) == 1));
      if (c > 0) begin
        chk("rr rvalid_a", 8'(rvalid_a_o[0]), 8'((c % 2) == 1));
        chk("rr rvalid_b", 8'(rvalid_b_o[0]), 8'((c % 2) == 0));
        chk("rr rdata", rdata_o[0], ((c % 2) == 1) ? 8'h12 : 8'h15);
      end
      next_cyc();
    end
    set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("rr last rvalid_b", 8'(rvalid_b_o[0]), 8'h01);
    chk("rr last rdata", rdata_o[0], 8'h15);
    next_cyc();

    // Write 0x5A to address 3, read it back the next cycle.
    set_a(1'b1, 1'b0, 1'b1, 3'd3, 8'h5A);
    settle();
    chk("wr mem_wr", 8'(mem_wr_o[0]), 8'h01);
    chk("wr mem_wraddr", 8'(mem_wraddr_o[0]), 8'h03);
    chk("wr mem_datain", mem_datain_o[0], 8'h5A);
    next_cyc();
    set_a(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
    settle();
    chk("rd mem_rd", 8'(mem_rd_o[0]), 8'h01);
    chk("rd mem_rdaddr", 8'(mem_rdaddr_o[0]), 8'h03);
    next_cyc();
    set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("raw rvalid_a", 8'(rvalid_a_o[0]), 8'h01);
    chk("raw rdata", rdata_o[0], 8'h5A);
    next_cyc();

    // B locks and runs 6 accesses while A keeps requesting.
    reset_pulse();
    set_b(1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
    settle();
    chk("blk grant gnt_b", 8'(gnt_b_o[0]), 8'h01);
    next_cyc();
    set_a(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      set_b(1'b1, 1'b1, (k % 2) == 0, 3'd6, 8'hC0 + 8'(k));
      settle();
      chk("blk gnt_a", 8'(gnt_a_o[0]), 8'h00);
      chk("blk gnt_b", 8'(gnt_b_o[0]), 8'h01);
      next_cyc();
    end
    set_b(1'b1, 1'b0, 1'b0, 3'd7, 8'h00);
    settle();
    chk("blk drop gnt_a", 8'(gnt_a_o[0]), 8'h00);
    chk("blk drop gnt_b", 8'(gnt_b_o[0]), 8'h01);
    next_cyc();
    settle();
    chk("blk after gnt_a", 8'(gnt_a_o[0]), 8'h01);
    chk("blk after gnt_b", 8'(gnt_b_o[0]), 8'h00);
    next_cyc();

    // MAX_LOCK limits: A first (priority passes to B), then B locks.
    reset_pulse();
    set_a(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("ml pre gnt_a", 8'(gnt_a_o[1]), 8'h01);
    next_cyc();
    set_a(1'b1, 1'b0, 1'b0, 3'd1, 8'h00);
    set_b(1'b1, 1'b1, 1'b0, 3'd2, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk("ml4 gnt_b", 8'(gnt_b_o[1]), 8'(k <= 4));
      chk("ml4 gnt_a", 8'(gnt_a_o[1]), 8'(k == 5));
      if (k <= 2) chk("ml1 gnt_b", 8'(gnt_b_o[2]), 8'(k == 1));
      next_cyc();
    end

    // Reset while A holds a lock with a read in flight.
    reset_pulse();
    set_a(1'b1, 1'b1, 1'b0, 3'd4, 8'h00);
    settle();
    chk("rl grant gnt_a", 8'(gnt_a_o[0]), 8'h01);
    next_cyc();
    settle();
    chk("rl locked mem_rd", 8'(mem_rd_o[0]), 8'h01);
    next_cyc();
    rst = 1'b1;
    set_b(1'b1, 1'b0, 1'b0, 3'd5, 8'h00);
    settle();
    chk("rl rst rvalid_a", 8'(rvalid_a_o[0]), 8'h00);
    chk("rl rst gnt_a", 8'(gnt_a_o[0]), 8'h00);
    chk("rl rst gnt_b", 8'(gnt_b_o[0]), 8'h00);
    chk("rl rst mem_rd", 8'(mem_rd_o[0]), 8'h00);
    next_cyc();
    rst = 1'b0;
    set_a(1'b1, 1'b0, 1'b0, 3'd4, 8'h00);
    settle();
    chk("rl post gnt_a", 8'(gnt_a_o[0]), 8'h01);
    chk("rl post gnt_b", 8'(gnt_b_o[0]), 8'h00);
    next_cyc();

    // Idle cycles, then a lone lock_b must not take ownership.
    set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("idle mem_wr", 8'(mem_wr_o[0]), 8'h00);
      chk("idle mem_rd", 8'(mem_rd_o[0]), 8'h00);
      next_cyc();
    end
    set_b(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    settle();
    chk("lone lock gnt_b", 8'(gnt_b_o[0]), 8'h00);
    next_cyc();
    set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_a(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("lone lock then gnt_a", 8'(gnt_a_o[0]), 8'h01);
    next_cyc();
    set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
